// File: rtl/feistel_dec.sv
// Iterative decryption engine for the 8-bit toy Feistel cipher.
// One inverse round every two cycles: registered S lookup (SUB), then mix/swap (MIX).
module feistel_dec #(
    parameter int ROUNDS = 4
) (
    input  logic        ck,
    input  logic        rst,
    input  logic        start,
    output logic        in_ready,
    input  logic [7:0]  ct,
    input  logic [15:0] key,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  pt
);

    localparam int IW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(ROUNDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SUB  = 2'd1,
        S_MIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_next;

    logic [3:0]    r_l;
    logic [3:0]    r_r;
    logic [15:0]   r_key;
    logic [IW-1:0] r_idx;
    logic [3:0]    r_s;
    logic [7:0]    r_pt;

    logic [1:0]    w_kidx;
    logic [3:0]    w_subkey;
    logic [3:0]    w_sin;
    logic [3:0]    w_sout;
    logic          w_last;

    // DES S1, restricted to the four columns reachable from a 4-bit input:
    // row = {x[0], x[3]}, column = {x[1], x[2]}.
    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [1:0] row;
        logic [1:0] col;
        logic [3:0] y;
        row = {x[0], x[3]};
        col = {x[1], x[2]};
        y   = 4'd0;
        case ({row, col})
            4'b00_00: y = 4'd14;
            4'b00_01: y = 4'd4;
            4'b00_10: y = 4'd13;
            4'b00_11: y = 4'd1;
            4'b01_00: y = 4'd0;
            4'b01_01: y = 4'd15;
            4'b01_10: y = 4'd7;
            4'b01_11: y = 4'd4;
            4'b10_00: y = 4'd4;
            4'b10_01: y = 4'd1;
            4'b10_10: y = 4'd14;
            4'b10_11: y = 4'd8;
            4'b11_00: y = 4'd15;
            4'b11_01: y = 4'd12;
            4'b11_10: y = 4'd8;
            4'b11_11: y = 4'd2;
            default:  y = 4'd0;
        endcase
        return y;
    endfunction

    assign w_kidx   = 2'(r_idx);
    assign w_subkey = r_key[{w_kidx, 2'b00} +: 4];
    assign w_sin    = r_l ^ w_subkey;
    assign w_sout   = sbox(w_sin);
    assign w_last   = (r_idx == '0);

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start)     w_next = S_SUB;
            S_SUB:                  w_next = S_MIX;
            S_MIX:   w_next = w_last ? S_DONE : S_SUB;
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default:                w_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            S_IDLE:  in_ready  = 1'b1;
            S_DONE:  out_valid = 1'b1;
            default: ;
        endcase
    end

    assign pt = r_pt;

    // The result is captured on the final MIX so pt never shows intermediate rounds.
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            r_l   <= 4'd0;
            r_r   <= 4'd0;
            r_key <= 16'd0;
            r_idx <= '0;
            r_s   <= 4'd0;
            r_pt  <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_l   <= ct[7:4];
                        r_r   <= ct[3:0];
                        r_key <= key;
                        r_idx <= LAST_IDX;
                    end
                end
                S_SUB: begin
                    r_s <= w_sout;
                end
                S_MIX: begin
                    r_l <= r_r ^ r_s;
                    r_r <= r_l;
                    if (w_last) begin
                        r_pt <= {r_r ^ r_s, r_l};
                    end else begin
                        r_idx <= r_idx - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
